// File: rtl/mult_shift_add_radix_pkg.sv
// Shared encodings and helpers for the iterative shift-and-add multiplier.
package mult_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_SIGN = SIGN
  } state_t;

  // Ceiling log2; the counter uses clog2(steps)+1 bits so it can hold the step count itself.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mult_shift_add_radix_pp_digit.sv
// Combinational digit * multiplicand partial product, as a sum of shifted gated copies.
module mult_pp_digit #(
  parameter int PP_WIDTH   = 512,
  parameter int RADIX_BITS = 1
) (
  input  logic [RADIX_BITS-1:0] digit,
  input  logic [PP_WIDTH-1:0]   multiplicand,
  output logic [PP_WIDTH-1:0]   product
);

  logic [PP_WIDTH-1:0] partial [RADIX_BITS+1];

  assign partial[0] = '0;

  generate
    for (genvar gi = 0; gi < RADIX_BITS; gi++) begin : g_term
      assign partial[gi+1] = partial[gi] + (digit[gi] ? (multiplicand << gi) : '0);
    end
  endgenerate

  assign product = partial[RADIX_BITS];

endmodule

// File: rtl/mult_shift_add_radix.sv
// Iterative radix-2^RADIX_BITS shift-and-add multiplier with signed mode, abort and busy flag.
module mult_shift_add_radix
  import mult_pkg::*;
#(
  parameter int WIDTH      = 256,
  parameter int RADIX_BITS = 1
) (
  input  logic               iClk,
  input  logic               iRstN,
  input  logic               iStart,
  input  logic               iAbort,
  input  logic               iSigned,
  input  logic [WIDTH-1:0]   iA,
  input  logic [WIDTH-1:0]   iB,
  output logic               oBusy,
  output logic               oDone,
  output logic [2*WIDTH-1:0] oX
);

  localparam int STEPS = WIDTH / RADIX_BITS;
  localparam int CNT_W = clog2(STEPS) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  generate
    if (!(RADIX_BITS == 1 || RADIX_BITS == 2 || RADIX_BITS == 4 || RADIX_BITS == 8) ||
        (WIDTH % RADIX_BITS) != 0) begin : g_bad_params
      $error("mult_shift_add_radix: RADIX_BITS must be 1/2/4/8 and divide WIDTH");
    end
  endgenerate

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     a_mag_reg, a_mag_next;
  logic [2*WIDTH-1:0]   b_sh_reg, b_sh_next;
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 neg_reg, neg_next;
  logic                 done_reg, done_next;
  logic [2*WIDTH-1:0]   pp;
  logic [WIDTH-1:0]     a_mag_in, b_mag_in;

  // Magnitudes only differ from the raw operands for negative signed inputs.
  assign a_mag_in = (iSigned && iA[WIDTH-1]) ? -iA : iA;
  assign b_mag_in = (iSigned && iB[WIDTH-1]) ? -iB : iB;

  mult_pp_digit #(
    .PP_WIDTH  (2*WIDTH),
    .RADIX_BITS(RADIX_BITS)
  ) u_pp_digit (
    .digit       (a_mag_reg[RADIX_BITS-1:0]),
    .multiplicand(b_sh_reg),
    .product     (pp)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_reg <= ST_IDLE;
      a_mag_reg <= '0;
      b_sh_reg  <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      neg_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_mag_reg <= a_mag_next;
      b_sh_reg  <= b_sh_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      neg_reg   <= neg_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_mag_next = a_mag_reg;
    b_sh_next  = b_sh_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    neg_next   = neg_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (iStart && !iAbort) begin
          state_next = ST_RUN;
          a_mag_next = a_mag_in;
          b_sh_next  = {{WIDTH{1'b0}}, b_mag_in};
          neg_next   = iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
          acc_next   = '0;
          cnt_next   = '0;
        end
      end
      ST_RUN: begin
        if (iAbort) begin
          state_next = ST_IDLE;
          acc_next   = '0;
          cnt_next   = '0;
        end else begin
          acc_next   = acc_reg + pp;
          a_mag_next = a_mag_reg >> RADIX_BITS;
          b_sh_next  = b_sh_reg << RADIX_BITS;
          cnt_next   = cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_STEP) begin
            state_next = ST_SIGN;
          end
        end
      end
      ST_SIGN: begin
        state_next = ST_IDLE;
        if (iAbort) begin
          acc_next = '0;
          cnt_next = '0;
        end else begin
          // Always visited so latency does not depend on the sign of the result.
          if (neg_reg) begin
            acc_next = -acc_reg;
          end
          done_next = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign oBusy = (state_reg != ST_IDLE);
  assign oDone = done_reg;
  assign oX    = acc_reg;

endmodule

// File: tb/tb_mult_shift_add_radix.sv
// Scoreboard bench: stimulus pushes expected products, a monitor pops them on each oDone.
module tb_mult_shift_add_radix;

  typedef struct {
    logic [511:0] x;
    int           cyc;
  } exp_t;

  localparam logic [511:0] EXP_ONES = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t q_big[$];
  exp_t q_r4[$];
  exp_t q_r2[$];

  logic         start_big = 0, abort_big = 0, sg_big = 0;
  logic [255:0] a_big = '0, b_big = '0;
  logic         busy_big, done_big;
  logic [511:0] x_big;

  logic         start_r4 = 0, abort_r4 = 0, sg_r4 = 0;
  logic [7:0]   a_r4 = '0, b_r4 = '0;
  logic         busy_r4, done_r4;
  logic [15:0]  x_r4;

  logic         start_r2 = 0, abort_r2 = 0, sg_r2 = 0;
  logic [7:0]   a_r2 = '0, b_r2 = '0;
  logic         busy_r2, done_r2;
  logic [15:0]  x_r2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_shift_add_radix #(.WIDTH(256), .RADIX_BITS(1)) u_big (
    .iClk(clk), .iRstN(rst_n), .iStart(start_big), .iAbort(abort_big), .iSigned(sg_big),
    .iA(a_big), .iB(b_big), .oBusy(busy_big), .oDone(done_big), .oX(x_big)
  );

  mult_shift_add_radix #(.WIDTH(8), .RADIX_BITS(4)) u_r4 (
    .iClk(clk), .iRstN(rst_n), .iStart(start_r4), .iAbort(abort_r4), .iSigned(sg_r4),
    .iA(a_r4), .iB(b_r4), .oBusy(busy_r4), .oDone(done_r4), .oX(x_r4)
  );

  mult_shift_add_radix #(.WIDTH(8), .RADIX_BITS(2)) u_r2 (
    .iClk(clk), .iRstN(rst_n), .iStart(start_r2), .iAbort(abort_r2), .iSigned(sg_r2),
    .iA(a_r2), .iB(b_r2), .oBusy(busy_r2), .oDone(done_r2), .oX(x_r2)
  );

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic done_of(input int which);
    case (which)
      0:       return done_big;
      1:       return done_r4;
      default: return done_r2;
    endcase
  endfunction

  task automatic wait_done(input int which, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done_of(which)) return;
      tick;
    end
    check("wait_done_timeout", 512'(done_of(which)), 512'(1));
  endtask

  // Each go_* call issues a start accepted at the next edge; oDone is due STEPS+1 edges later.
  task automatic go_big(input logic [255:0] a, input logic [255:0] b, input logic [511:0] exp_x,
                        input bit push);
    exp_t e;
    a_big = a; b_big = b; sg_big = 1'b0;
    if (push) begin
      e.x = exp_x; e.cyc = cyc + 258;
      q_big.push_back(e);
    end
    start_big = 1'b1;
    tick;
    start_big = 1'b0;
  endtask

  task automatic go_r4(input logic [7:0] a, input logic [7:0] b, input logic sg,
                       input logic [15:0] exp_x, input bit push);
    exp_t e;
    a_r4 = a; b_r4 = b; sg_r4 = sg;
    if (push) begin
      e.x = 512'(exp_x); e.cyc = cyc + 4;
      q_r4.push_back(e);
    end
    start_r4 = 1'b1;
    tick;
    start_r4 = 1'b0;
  endtask

  task automatic go_r2(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_x,
                       input bit push);
    exp_t e;
    a_r2 = a; b_r2 = b; sg_r2 = 1'b0;
    if (push) begin
      e.x = 512'(exp_x); e.cyc = cyc + 6;
      q_r2.push_back(e);
    end
    start_r2 = 1'b1;
    tick;
    start_r2 = 1'b0;
  endtask

  // Monitor: compare product, completion cycle and busy on every oDone pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done_big) begin
          if (q_big.size() == 0) begin
            check("big_spurious_done", 512'(done_big), 512'(0));
          end else begin
            e = q_big.pop_front();
            check("big_x", x_big, e.x);
            check("big_done_cycle", 512'(cyc), 512'(e.cyc));
            check("big_busy_at_done", 512'(busy_big), 512'(0));
          end
        end
        if (done_r4) begin
          if (q_r4.size() == 0) begin
            check("r4_spurious_done", 512'(done_r4), 512'(0));
          end else begin
            e = q_r4.pop_front();
            check("r4_x", 512'(x_r4), e.x);
            check("r4_done_cycle", 512'(cyc), 512'(e.cyc));
            check("r4_busy_at_done", 512'(busy_r4), 512'(0));
          end
        end
        if (done_r2) begin
          if (q_r2.size() == 0) begin
            check("r2_spurious_done", 512'(done_r2), 512'(0));
          end else begin
            e = q_r2.pop_front();
            check("r2_x", 512'(x_r2), e.x);
            check("r2_done_cycle", 512'(cyc), 512'(e.cyc));
            check("r2_busy_at_done", 512'(busy_r2), 512'(0));
          end
        end
      end
    end
  end

  initial begin
    int dones;
    #12;
    check("rst_big_x", x_big, 512'(0));
    check("rst_big_busy", 512'(busy_big), 512'(0));
    check("rst_big_done", 512'(done_big), 512'(0));
    check("rst_r4_x", 512'(x_r4), 512'(0));
    check("rst_r2_busy", 512'(busy_r2), 512'(0));
    rst_n = 1'b1;
    tick;

    // Unsigned all-ones at default parameters.
    go_big('1, '1, EXP_ONES, 1'b1);
    check("big_busy_run", 512'(busy_big), 512'(1));
    repeat (256) tick;
    check("big_busy_sign", 512'(busy_big), 512'(1));
    check("big_no_early_done", 512'(done_big), 512'(0));
    wait_done(0, 5);
    tick;

    // Signed radix-16, chained back to back from each oDone cycle.
    go_r4(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b1);
    wait_done(1, 10);
    go_r4(8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
    check("r4_x_cleared_at_start", 512'(x_r4), 512'(0));
    check("r4_busy_after_start", 512'(busy_r4), 512'(1));
    wait_done(1, 10);
    go_r4(8'h7F, 8'h80, 1'b1, 16'hC080, 1'b1);
    wait_done(1, 10);
    tick;

    // Unsigned radix-4 with an ignored mid-run start.
    go_r2(8'd200, 8'd0, 16'h0000, 1'b1);
    tick;
    a_r2 = 8'd1; b_r2 = 8'd255; start_r2 = 1'b1;
    tick;
    start_r2 = 1'b0;
    wait_done(2, 10);
    tick;
    go_r2(8'd1, 8'd255, 16'h00FF, 1'b1);
    wait_done(2, 10);
    tick;

    // Abort at RUN cycle 100, then abort-beats-start in IDLE, then a clean run.
    go_big('1, '1, '0, 1'b0);
    repeat (99) tick;
    abort_big = 1'b1;
    tick;
    abort_big = 1'b0;
    check("abort_x", x_big, 512'(0));
    check("abort_busy", 512'(busy_big), 512'(0));
    dones = 0;
    repeat (300) begin
      tick;
      if (done_big) dones++;
    end
    check("abort_no_done", 512'(dones), 512'(0));
    a_big = 256'd5; b_big = 256'd5; start_big = 1'b1; abort_big = 1'b1;
    tick;
    start_big = 1'b0; abort_big = 1'b0;
    check("abort_beats_start", 512'(busy_big), 512'(0));
    go_big(256'd3, 256'd7, 512'd21, 1'b1);
    wait_done(0, 300);
    tick;

    // Asynchronous reset between clock edges during RUN.
    go_r4(8'd100, 8'd100, 1'b0, 16'h0000, 1'b0);
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_x", 512'(x_r4), 512'(0));
    check("async_rst_busy", 512'(busy_r4), 512'(0));
    check("async_rst_done", 512'(done_r4), 512'(0));
    #3;
    rst_n = 1'b1;
    tick;
    go_r4(8'd12, 8'd12, 1'b0, 16'h0090, 1'b1);
    wait_done(1, 10);
    tick;
    tick;

    check("scoreboard_drained", 512'(q_big.size() + q_r4.size() + q_r2.size()), 512'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
